// File: rtl/bip_datapath.sv
// Accumulator datapath for a basic instruction processor: ACC register, add/sub
// ALU with sticky signed-overflow flag, and a word-addressed data memory.
module bip_datapath #(
  parameter int NB_DATA          = 16,
  parameter int NB_ADDR          = 11,
  parameter int NB_DECODER_SEL_A = 2,
  parameter int RAM_DEPTH        = 2048
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NB_ADDR-1:0]          i_operand,
  input  logic [NB_DECODER_SEL_A-1:0] i_selA,
  input  logic                        i_selB,
  input  logic                        i_wrAcc,
  input  logic                        i_op,
  input  logic                        i_wrRam,
  input  logic                        i_rdRam,
  output logic [NB_DATA-1:0]          o_acc,
  output logic                        o_zero,
  output logic                        o_ovf
);

  localparam int unsigned AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic [NB_DATA-1:0] acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [NB_DATA-1:0] mem_q [RAM_DEPTH];

  logic               in_range;
  logic [AW-1:0]      idx;
  logic [NB_DATA-1:0] imm;
  logic [NB_DATA-1:0] mem_word;
  logic [NB_DATA-1:0] opnd_b;
  logic [NB_DATA-1:0] alu_res;
  logic               alu_ovf;
  logic               sign_a, sign_b, sign_r;

  // Out-of-range addresses never touch the array, so truncating the index is safe.
  assign in_range = (32'(i_operand) < 32'(RAM_DEPTH));
  assign idx      = i_operand[AW-1:0];

  assign imm      = {{(NB_DATA-NB_ADDR){i_operand[NB_ADDR-1]}}, i_operand};
  assign mem_word = (i_rdRam && in_range) ? mem_q[idx] : '0;
  assign opnd_b   = i_selB ? imm : mem_word;
  assign alu_res  = i_op ? (acc_q - opnd_b) : (acc_q + opnd_b);

  assign sign_a  = acc_q[NB_DATA-1];
  assign sign_b  = opnd_b[NB_DATA-1];
  assign sign_r  = alu_res[NB_DATA-1];
  assign alu_ovf = i_op ? ((sign_a != sign_b) && (sign_r != sign_a))
                        : ((sign_a == sign_b) && (sign_r != sign_a));

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (i_wrAcc) begin
      case (i_selA)
        NB_DECODER_SEL_A'(0): acc_d = mem_word;
        NB_DECODER_SEL_A'(1): acc_d = imm;
        NB_DECODER_SEL_A'(2): begin
          acc_d = alu_res;
          ovf_d = ovf_q | alu_ovf;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  // Memory has no reset; writes are gated by the reset level instead.
  always_ff @(posedge i_clk) begin
    if (i_rst && i_wrRam && in_range) begin
      mem_q[idx] <= acc_q;
    end
  end

  assign o_acc  = acc_q;
  assign o_zero = (acc_q == '0);
  assign o_ovf  = ovf_q;

endmodule

// File: tb/tb_bip_datapath.sv
// Directed bench for bip_datapath; RAM_DEPTH reduced so out-of-range addresses exist.
module tb_bip_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] operand;
  logic [1:0]  selA;
  logic        selB, wrAcc, op, wrRam, rdRam;
  logic [15:0] acc;
  logic        zero, ovf;

  int checks = 0;
  int errors = 0;

  bip_datapath #(
    .NB_DATA(16),
    .NB_ADDR(11),
    .NB_DECODER_SEL_A(2),
    .RAM_DEPTH(1024)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .i_operand(operand),
    .i_selA(selA),
    .i_selB(selB),
    .i_wrAcc(wrAcc),
    .i_op(op),
    .i_wrRam(wrRam),
    .i_rdRam(rdRam),
    .o_acc(acc),
    .o_zero(zero),
    .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic [1:0] sa, input logic sb, input logic o,
                     input logic wa, input logic wr, input logic rd,
                     input logic [10:0] opd);
    selA = sa; selB = sb; op = o; wrAcc = wa; wrRam = wr; rdRam = rd; operand = opd;
  endtask

  task automatic ld_imm(input logic [10:0] v);
    set(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, v); tick();
  endtask
  task automatic ld_mem(input logic [10:0] a);
    set(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, a); tick();
  endtask
  task automatic st(input logic [10:0] a);
    set(2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a); tick();
  endtask
  task automatic alu_imm(input logic o, input logic [10:0] v);
    set(2'd2, 1'b1, o, 1'b1, 1'b0, 1'b0, v); tick();
  endtask
  task automatic alu_mem(input logic o, input logic [10:0] a);
    set(2'd2, 1'b0, o, 1'b1, 1'b0, 1'b1, a); tick();
  endtask

  initial begin
    rst_n = 1'b0;
    set(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
    #2;
    chk("reset_acc", acc, 16'h0000);
    chk("reset_zero", {15'd0, zero}, 16'd1);
    chk("reset_ovf", {15'd0, ovf}, 16'd0);
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();

    ld_imm(11'h7FF); chk("imm_neg_sext", acc, 16'hFFFF);
    ld_imm(11'h3FF); chk("imm_pos", acc, 16'h03FF);

    // 0x234 + 4*1024 built by subtracting the sign-extended immediate 0x400 (-1024)
    ld_imm(11'h234);
    for (int i = 0; i < 4; i++) alu_imm(1'b1, 11'h400);
    chk("build_1234", acc, 16'h1234);

    st(11'd5);
    ld_imm(11'd0); chk("clear_zero", {15'd0, zero}, 16'd1);
    ld_mem(11'd5); chk("store_load", acc, 16'h1234);
    set(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'd5); tick();
    chk("rd_disabled_zero", acc, 16'h0000);

    ld_imm(11'd10);
    alu_imm(1'b0, 11'd3);  chk("add_imm", acc, 16'd13);
    alu_imm(1'b1, 11'd13); chk("sub_to_zero", acc, 16'd0);
    chk("sub_zero_flag", {15'd0, zero}, 16'd1);
    alu_mem(1'b0, 11'd5);  chk("add_mem", acc, 16'h1234);

    ld_imm(11'd1);
    for (int i = 0; i < 14; i++) begin
      st(11'd0);
      alu_mem(1'b0, 11'd0);
    end
    chk("double_4000", acc, 16'h4000);
    st(11'd1);
    alu_imm(1'b1, 11'd1);
    alu_mem(1'b0, 11'd1);  chk("build_7fff", acc, 16'h7FFF);
    chk("no_ovf_yet", {15'd0, ovf}, 16'd0);
    alu_imm(1'b0, 11'd1);  chk("ovf_add_acc", acc, 16'h8000);
    chk("ovf_add_flag", {15'd0, ovf}, 16'd1);
    alu_imm(1'b1, 11'd1);  chk("ovf_sub_acc", acc, 16'h7FFF);
    chk("ovf_sub_flag", {15'd0, ovf}, 16'd1);
    ld_imm(11'd0);         chk("ovf_sticky", {15'd0, ovf}, 16'd1);

    ld_imm(11'h155);
    for (int i = 0; i < 21; i++) alu_imm(1'b1, 11'h400);
    chk("build_5555", acc, 16'h5555);
    st(11'd8);
    alu_mem(1'b0, 11'd8);  chk("build_aaaa", acc, 16'hAAAA);
    st(11'd7);
    alu_mem(1'b1, 11'd8);  chk("back_5555", acc, 16'h5555);
    set(2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 11'd7); tick();
    chk("rw_same_cycle_old", acc, 16'hAAAA);
    ld_mem(11'd7);         chk("rw_next_cycle_new", acc, 16'h5555);
    set(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd1); tick();
    chk("wracc0_hold", acc, 16'h5555);

    st(11'h400);
    st(11'h405);
    ld_mem(11'h405);       chk("oor_read_zero", acc, 16'h0000);
    ld_mem(11'd5);         chk("oor_no_alias5", acc, 16'h1234);
    ld_mem(11'd0);         chk("oor_no_alias0", acc, 16'h2000);

    ld_imm(11'h0FF);       chk("pre_reset_acc", acc, 16'h00FF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_acc", acc, 16'h0000);
    chk("async_rst_ovf", {15'd0, ovf}, 16'd0);
    chk("async_rst_zero", {15'd0, zero}, 16'd1);
    set(2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 11'd5); tick();
    chk("rst_hold_acc", acc, 16'h0000);
    set(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 11'd5);
    #2 rst_n = 1'b1;
    tick();
    chk("rst_mem_kept_first_edge", acc, 16'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
